multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 49 ++++
 rtl/multicycle_ctrl_decode.sv | 50 +++++
 rtl/multicycle_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: instruction and ALU opcodes,
// instruction field positions, decode classes and the controller FSM states.
package multicycle_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_LI   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_NOP  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // ALU opcodes are also decoded by the ALU itself, so they live here.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0010;
    localparam logic [3:0] ALU_LI  = 4'b0011;

    localparam int OPC_HI = 36;
    localparam int OPC_LO = 33;
    localparam int RD_HI  = 32;
    localparam int RD_LO  = 28;
    localparam int RS1_HI = 27;
    localparam int RS1_LO = 23;
    localparam int RS2_HI = 22;
    localparam int RS2_LO = 18;
    localparam int IMM_HI = 17;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = IMM_HI - IMM_LO + 1;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_BRANCH  = 3'd1,
        CLS_NOP     = 3'd2,
        CLS_HALT    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } iclass_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        BRANCH    = 3'd4,
        HALT_ST   = 3'd5
    } state_e;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode lookup: instruction opcode -> ALU opcode, operand-2 select
// and instruction class used by the controller FSM.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic [3:0] alu_op_o,
    output logic       alu_src_imm_o,
    output logic [2:0] iclass_o
);

    always_comb begin
        alu_op_o      = ALU_ADD;
        alu_src_imm_o = 1'b0;
        iclass_o      = CLS_ILLEGAL;
        case (opcode_i)
            OP_ADD: begin
                alu_op_o = ALU_ADD;
                iclass_o = CLS_ALU;
            end
            OP_SUB: begin
                alu_op_o = ALU_SUB;
                iclass_o = CLS_ALU;
            end
            OP_SLT: begin
                alu_op_o = ALU_SLT;
                iclass_o = CLS_ALU;
            end
            OP_LI: begin
                alu_op_o      = ALU_LI;
                alu_src_imm_o = 1'b1;
                iclass_o      = CLS_ALU;
            end
            OP_ADDI: begin
                alu_op_o      = ALU_ADD;
                alu_src_imm_o = 1'b1;
                iclass_o      = CLS_ALU;
            end
            // BEQ compares rs1 and rs2 by subtraction and reads back alu_zero.
            OP_BEQ: begin
                alu_op_o = ALU_SUB;
                iclass_o = CLS_BRANCH;
            end
            OP_NOP:  iclass_o = CLS_NOP;
            OP_HALT: iclass_o = CLS_HALT;
            default: iclass_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction controller: IDLE -> DECODE -> EXECUTE -> WRITEBACK/BRANCH.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT_ST (adds illegal_op).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int DATA_W  = 48,
    parameter int INSTR_W = 37
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               alu_zero,
    output logic [3:0]         alu_op,
    output logic               alu_src_imm,
    output logic [DATA_W-1:0]  imm_ext,
    output logic [4:0]         rf_raddr1,
    output logic [4:0]         rf_raddr2,
    output logic [4:0]         rf_waddr,
    output logic               rf_we,
    output logic               branch_taken,
    output logic               halted
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic               illegal_op
`endif
);

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    state_e              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [3:0]          alu_op_q, alu_op_d;
    logic                src_imm_q, src_imm_d;
    logic [DATA_W-1:0]   imm_ext_q, imm_ext_d;
    logic                zero_q, zero_d;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic                illegal_q, illegal_d;
`endif

    logic [3:0]          dec_alu_op;
    logic                dec_src_imm;
    logic [2:0]          dec_class;

    ctrl_decode u_decode (
        .opcode_i      (instr_q[OPC_HI:OPC_LO]),
        .alu_op_o      (dec_alu_op),
        .alu_src_imm_o (dec_src_imm),
        .iclass_o      (dec_class)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            alu_op_q  <= '0;
            src_imm_q <= 1'b0;
            imm_ext_q <= '0;
            zero_q    <= 1'b0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            alu_op_q  <= alu_op_d;
            src_imm_q <= src_imm_d;
            imm_ext_q <= imm_ext_d;
            zero_q    <= zero_d;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        alu_op_d  = alu_op_q;
        src_imm_d = src_imm_q;
        imm_ext_d = imm_ext_q;
        zero_d    = zero_q;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            // The instruction word is only sampled here, so later changes on instr are ignored.
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_op_d  = dec_alu_op;
                src_imm_d = dec_src_imm;
                imm_ext_d = sext_imm(instr_q[IMM_HI:IMM_LO]);
                case (dec_class)
                    CLS_ALU, CLS_BRANCH: state_d = EXECUTE;
                    CLS_HALT:            state_d = HALT_ST;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    CLS_ILLEGAL: begin
                        state_d   = HALT_ST;
                        illegal_d = 1'b1;
                    end
`endif
                    default:             state_d = IDLE;
                endcase
            end
            EXECUTE: begin
                zero_d  = alu_zero;
                state_d = (dec_class == CLS_BRANCH) ? BRANCH : WRITEBACK;
            end
            WRITEBACK: state_d = IDLE;
            BRANCH:    state_d = IDLE;
            HALT_ST:   state_d = HALT_ST;
            default:   state_d = IDLE;
        endcase
    end

    // WRITEBACK and BRANCH are distinct states, so rf_we and branch_taken never overlap.
    assign instr_ready  = (state_q == IDLE);
    assign rf_we        = (state_q == WRITEBACK) && (instr_q[RD_HI:RD_LO] != 5'd0);
    assign branch_taken = (state_q == BRANCH) && zero_q;
    assign halted       = (state_q == HALT_ST);
    assign rf_waddr     = instr_q[RD_HI:RD_LO];
    assign rf_raddr1    = instr_q[RS1_HI:RS1_LO];
    assign rf_raddr2    = instr_q[RS2_HI:RS2_LO];
    assign alu_op       = alu_op_q;
    assign alu_src_imm  = src_imm_q;
    assign imm_ext      = imm_ext_q;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    assign illegal_op   = illegal_q;
`endif

endmodule
